// File: rtl/ifu_fetch_bridge_pkg.sv
// Shared frontend definitions for the fetch bridge: FSM state encoding and
// the fetch-line geometry used to align request addresses.
package ifu_fetch_bridge_pkg;

   typedef enum logic [2:0] {
      FB_IDLE  = 3'd0,
      FB_REQ   = 3'd1,
      FB_RESP  = 3'd2,
      FB_DRAIN = 3'd3,
      FB_DONE  = 3'd4
   } fb_state_e;

   localparam int unsigned LINE_BYTES = 16;
   localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);

endpackage

// File: rtl/ifu_line_assembler.sv
// Beat counter plus line register: collects BEAT_W-wide response beats into
// one LINE_W line, beat 0 in the least significant slot.
module ifu_line_assembler #(
   parameter  int unsigned LINE_W = 128,
   parameter  int unsigned BEAT_W = 64,
   localparam int unsigned BEATS  = LINE_W / BEAT_W,
   localparam int unsigned CNT_W  = $clog2(BEATS) + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              count,
   input  logic              write,
   input  logic [BEAT_W-1:0] beat_data,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic [LINE_W-1:0] line
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);

   // Counter saturates at BEATS so a drain can tell "all beats already taken".
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
      end else if (clear) begin
         beat_cnt <= '0;
      end else if (count && (beat_cnt != FULL)) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line <= '0;
      end else if (write) begin
         for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_cnt == CNT_W'(i)) begin
               line[i*BEAT_W +: BEAT_W] <= beat_data;
            end
         end
      end
   end

endmodule

// File: rtl/ifu_fetch_bridge.sv
// Fetch bridge: converts pc_ctrl fetch requests into single line reads,
// assembles the response beats and squashes in-flight reads on redirect.
module ifu_fetch_bridge
   import ifu_fetch_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned LINE_W = 128,
   parameter int unsigned BEAT_W = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pc_index_valid,
   input  logic [ADDR_W-1:0] pc_index,
   output logic              pc_index_ready,
   output logic              pc_operation_done,
   output logic [LINE_W-1:0] pc_read_inst,
   input  logic              redirect_valid,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [BEAT_W-1:0] mem_resp_data,
   output logic              mem_stall
);

   localparam int unsigned BEATS = LINE_W / BEAT_W;
   localparam int unsigned CNT_W = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);

   fb_state_e        state;
   fb_state_e        state_next;
   logic [CNT_W-1:0] beat_cnt;
   logic             handshake;
   logic             asm_clear;
   logic             asm_count;
   logic             asm_write;

   assign handshake = pc_index_valid && pc_index_ready;
   assign asm_clear = (state == FB_REQ) && mem_req_ready;
   assign asm_count = mem_resp_valid && ((state == FB_RESP) || (state == FB_DRAIN));
   assign asm_write = mem_resp_valid && (state == FB_RESP);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= FB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_req_addr <= '0;
      end else if (handshake) begin
         mem_req_addr <= {pc_index[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
      end
   end

   always_comb begin
      state_next        = state;
      pc_index_ready    = 1'b0;
      pc_operation_done = 1'b0;
      mem_req_valid     = 1'b0;
      mem_stall         = (state != FB_IDLE);
      unique case (state)
         FB_IDLE: begin
            pc_index_ready = !redirect_valid;
            if (pc_index_valid && !redirect_valid) state_next = FB_REQ;
         end
         FB_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_next = redirect_valid ? FB_DRAIN : FB_RESP;
            else if (redirect_valid) state_next = FB_IDLE;
         end
         FB_RESP: begin
            // A beat arriving with the redirect is already counted, so DRAIN
            // may find every beat taken and leave immediately.
            if (redirect_valid) state_next = FB_DRAIN;
            else if (mem_resp_valid && (beat_cnt == LAST)) state_next = FB_DONE;
         end
         FB_DRAIN: begin
            if ((beat_cnt == FULL) || (mem_resp_valid && (beat_cnt == LAST))) state_next = FB_IDLE;
         end
         FB_DONE: begin
            pc_operation_done = !redirect_valid;
            state_next        = FB_IDLE;
         end
         default: state_next = FB_IDLE;
      endcase
   end

   ifu_line_assembler #(
      .LINE_W (LINE_W),
      .BEAT_W (BEAT_W)
   ) u_line_assembler (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (asm_clear),
      .count     (asm_count),
      .write     (asm_write),
      .beat_data (mem_resp_data),
      .beat_cnt  (beat_cnt),
      .line      (pc_read_inst)
   );

   resp_outside_window : assert property (@(posedge clock) disable iff (!reset_n)
      !(mem_resp_valid && ((state == FB_IDLE) || (state == FB_REQ) || (state == FB_DONE))));

endmodule

// File: tb/tb_ifu_fetch_bridge.sv
// Directed bench for ifu_fetch_bridge: table of clean fetches plus
// hand-written redirect, stall and reset sequences.
module tb_ifu_fetch_bridge;

   logic         clock;
   logic         reset_n;
   logic         pc_index_valid;
   logic [63:0]  pc_index;
   logic         pc_index_ready;
   logic         pc_operation_done;
   logic [127:0] pc_read_inst;
   logic         redirect_valid;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic [63:0]  mem_req_addr;
   logic         mem_resp_valid;
   logic [63:0]  mem_resp_data;
   logic         mem_stall;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0]  pc;
      logic [63:0]  b0;
      logic [63:0]  b1;
      logic [63:0]  addr;
      logic [127:0] line;
   } vec_t;

   vec_t vecs[4];

   ifu_fetch_bridge #(
      .ADDR_W (64),
      .LINE_W (128),
      .BEAT_W (64)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .pc_index_valid    (pc_index_valid),
      .pc_index          (pc_index),
      .pc_index_ready    (pc_index_ready),
      .pc_operation_done (pc_operation_done),
      .pc_read_inst      (pc_read_inst),
      .redirect_valid    (redirect_valid),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_addr      (mem_req_addr),
      .mem_resp_valid    (mem_resp_valid),
      .mem_resp_data     (mem_resp_data),
      .mem_stall         (mem_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   task automatic handshake(input logic [63:0] pc);
      pc_index_valid = 1'b1;
      pc_index       = pc;
      @(negedge clock);
      chk("hs_ready", 128'(pc_index_ready), 128'(1));
      nxt();
      pc_index_valid = 1'b0;
   endtask

   // Zero-wait fetch: done must appear exactly 4 cycles after the handshake.
   task automatic fetch(input logic [63:0] pc, input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] exp_addr, input logic [127:0] exp_line);
      handshake(pc);
      mem_req_ready = 1'b1;
      @(negedge clock);
      chk("req_valid", 128'(mem_req_valid), 128'(1));
      chk("req_addr", 128'(mem_req_addr), 128'(exp_addr));
      chk("req_stall", 128'(mem_stall), 128'(1));
      chk("req_ready_low", 128'(pc_index_ready), 128'(0));
      nxt();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = b0;
      @(negedge clock);
      chk("beat0_no_done", 128'(pc_operation_done), 128'(0));
      nxt();
      mem_resp_data = b1;
      @(negedge clock);
      chk("beat1_no_done", 128'(pc_operation_done), 128'(0));
      nxt();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("done_pulse", 128'(pc_operation_done), 128'(1));
      chk("done_line", pc_read_inst, exp_line);
      nxt();
      @(negedge clock);
      chk("done_once", 128'(pc_operation_done), 128'(0));
      chk("line_hold", pc_read_inst, exp_line);
      chk("idle_stall", 128'(mem_stall), 128'(0));
      nxt();
   endtask

   initial begin
      vecs[0] = '{64'h0000_0000_8000_0008, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h0000_0000_8000_0000, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
      vecs[1] = '{64'h0000_0000_1234_567F, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002,
                  64'h0000_0000_1234_5670, {64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001}};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'hFFFF_FFFF_FFFF_FFF0, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};
      vecs[3] = '{64'h0000_0000_0000_0010, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0,
                  64'h0000_0000_0000_0010, {64'h0F0F_0F0F_F0F0_F0F0, 64'hA5A5_A5A5_5A5A_5A5A}};

      reset_n        = 1'b0;
      pc_index_valid = 1'b0;
      pc_index       = '0;
      redirect_valid = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      #1;
      chk("rst_done", 128'(pc_operation_done), 128'(0));
      chk("rst_req_valid", 128'(mem_req_valid), 128'(0));
      chk("rst_req_addr", 128'(mem_req_addr), 128'(0));
      chk("rst_line", pc_read_inst, 128'(0));
      chk("rst_stall", 128'(mem_stall), 128'(0));
      nxt();
      nxt();
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle_ready", 128'(pc_index_ready), 128'(1));
      nxt();

      for (int i = 0; i < 4; i++) begin
         fetch(vecs[i].pc, vecs[i].b0, vecs[i].b1, vecs[i].addr, vecs[i].line);
      end

      // Request backpressure for 5 cycles.
      handshake(64'h0000_0000_4000_0024);
      mem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_req_valid", 128'(mem_req_valid), 128'(1));
         chk("bp_req_addr", 128'(mem_req_addr), 128'(64'h4000_0020));
         chk("bp_ready_low", 128'(pc_index_ready), 128'(0));
         chk("bp_stall", 128'(mem_stall), 128'(1));
         nxt();
      end
      mem_req_ready = 1'b1;
      @(negedge clock);
      chk("bp_no_done0", 128'(pc_operation_done), 128'(0));
      nxt();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h5555_5555_5555_5555;
      @(negedge clock);
      chk("bp_no_done1", 128'(pc_operation_done), 128'(0));
      nxt();
      mem_resp_data = 64'h6666_6666_6666_6666;
      @(negedge clock);
      chk("bp_no_done2", 128'(pc_operation_done), 128'(0));
      nxt();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("bp_done", 128'(pc_operation_done), 128'(1));
      chk("bp_line", pc_read_inst, {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
      nxt();

      // Redirect in RESP after beat 0; beat 1 is drained.
      handshake(64'h0000_0000_0000_2000);
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hAAAA_AAAA_AAAA_AAAA;
      nxt();
      mem_resp_valid = 1'b0;
      redirect_valid = 1'b1;
      @(negedge clock);
      chk("rd_resp_ready", 128'(pc_index_ready), 128'(0));
      chk("rd_resp_done", 128'(pc_operation_done), 128'(0));
      nxt();
      redirect_valid = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hBBBB_BBBB_BBBB_BBBB;
      @(negedge clock);
      chk("drain_done", 128'(pc_operation_done), 128'(0));
      chk("drain_stall", 128'(mem_stall), 128'(1));
      nxt();
      mem_resp_valid = 1'b0;
      @(negedge clock);
      chk("drain_exit_ready", 128'(pc_index_ready), 128'(1));
      chk("drain_exit_stall", 128'(mem_stall), 128'(0));
      chk("drain_exit_done", 128'(pc_operation_done), 128'(0));
      nxt();
      fetch(64'h0000_0000_0000_3008, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
            64'h0000_0000_0000_3000, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333});

      // Redirect in the DONE cycle suppresses the pulse.
      handshake(64'h0000_0000_0000_7000);
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h7777_7777_7777_7777;
      nxt();
      mem_resp_data = 64'h8888_8888_8888_8888;
      nxt();
      mem_resp_valid = 1'b0;
      redirect_valid = 1'b1;
      @(negedge clock);
      chk("rd_done_gated", 128'(pc_operation_done), 128'(0));
      chk("rd_done_line", pc_read_inst, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777});
      nxt();
      redirect_valid = 1'b0;
      @(negedge clock);
      chk("rd_done_idle_stall", 128'(mem_stall), 128'(0));
      chk("rd_done_idle_ready", 128'(pc_index_ready), 128'(1));
      nxt();

      // Redirect in REQ without memory acceptance drops the request.
      handshake(64'h0000_0000_0000_9000);
      mem_req_ready  = 1'b0;
      redirect_valid = 1'b1;
      @(negedge clock);
      chk("rd_req_valid", 128'(mem_req_valid), 128'(1));
      nxt();
      redirect_valid = 1'b0;
      @(negedge clock);
      chk("rd_req_stall", 128'(mem_stall), 128'(0));
      chk("rd_req_valid_low", 128'(mem_req_valid), 128'(0));
      chk("rd_req_ready", 128'(pc_index_ready), 128'(1));
      nxt();
      nxt();
      @(negedge clock);
      chk("rd_req_no_done", 128'(pc_operation_done), 128'(0));
      nxt();

      // Asynchronous reset in the middle of RESP.
      handshake(64'h0000_0000_0000_0500);
      mem_req_ready = 1'b1;
      nxt();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hC0C0_C0C0_C0C0_C0C0;
      nxt();
      mem_resp_valid = 1'b0;
      reset_n        = 1'b0;
      #1;
      chk("mid_rst_done", 128'(pc_operation_done), 128'(0));
      chk("mid_rst_req_valid", 128'(mem_req_valid), 128'(0));
      chk("mid_rst_addr", 128'(mem_req_addr), 128'(0));
      chk("mid_rst_line", pc_read_inst, 128'(0));
      chk("mid_rst_stall", 128'(mem_stall), 128'(0));
      nxt();
      reset_n = 1'b1;
      nxt();
      fetch(64'h0000_0000_0000_0100, 64'h0000_0000_0000_00D1, 64'h0000_0000_0000_00D2,
            64'h0000_0000_0000_0100, {64'h0000_0000_0000_00D2, 64'h0000_0000_0000_00D1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
